// File: rtl/sd_pkg.sv
// Shared types and defaults for the word-to-serial sequence detector slice.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } sd_state_e;

  localparam int unsigned         SD_PLEN    = 3;
  localparam logic [SD_PLEN-1:0]  SD_PATTERN = 3'b100;

  // Width needed to hold a per-word match count of 0..w.
  function automatic int unsigned sd_cw(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sd_match_core.sv
// Overlapping serial pattern matcher: registered bit history plus fill level,
// combinational (Mealy) match on the bit currently presented.
module sd_match_core
  import sd_pkg::*;
#(
  parameter int unsigned          PLEN    = SD_PLEN,
  parameter logic [PLEN-1:0]      PATTERN = SD_PATTERN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_in,
  input  logic bit_en,
  input  logic clr,
  output logic match
);

  localparam int unsigned     FW       = $clog2(PLEN);
  localparam logic [FW-1:0]   FILL_MAX = FW'(PLEN - 1);

  logic [PLEN-2:0] hist_q, hist_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [PLEN-1:0] window;

  assign window = {hist_q, bit_in};
  // Fill gates matches until PLEN-1 genuine history bits have been seen.
  assign match  = bit_en && (fill_q == FILL_MAX) && (window == PATTERN);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_en) begin
      hist_d = window[PLEN-2:0];
      if (fill_q != FILL_MAX) fill_d = fill_q + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/sd_stream_ctrl.sv
// Word-in / count-out controller: shifts each accepted word MSB-first through
// the serial matcher and reports the number of detections for that word.
module sd_stream_ctrl
  import sd_pkg::*;
#(
  parameter int unsigned       W       = 8,
  parameter int unsigned       PLEN    = SD_PLEN,
  parameter logic [PLEN-1:0]   PATTERN = SD_PATTERN,
  parameter int unsigned       CW      = sd_cw(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          hist_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic          out_hit,
  output logic          det_pulse,
  output logic          busy
);

  localparam int unsigned IW = $clog2(W);

  sd_state_e        state_q, state_d;
  logic [W-1:0]     shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             match;
  logic             bit_en;
  logic             core_clr;

  assign bit_en   = (state_q == SHIFT);
  // History clear is only honoured while idle, so it lands before the first bit.
  assign core_clr = hist_clr && (state_q == IDLE);

  sd_match_core #(
    .PLEN    (PLEN),
    .PATTERN (PATTERN)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .bit_in (shift_q[W-1]),
    .bit_en (bit_en),
    .clr    (core_clr),
    .match  (match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)        state_d = SHIFT;
      SHIFT:   if (idx_q == '0)     state_d = REPORT;
      REPORT:  if (out_ready)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && in_valid) begin
      shift_d = in_data;
      idx_d   = IW'(W - 1);
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      shift_d = {shift_q[W-2:0], 1'b0};
      idx_d   = idx_q - IW'(1);
      cnt_d   = cnt_q + CW'(match);
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == REPORT);
    busy      = (state_q != IDLE);
    det_pulse = match;
    out_count = cnt_q;
    out_hit   = (cnt_q != '0);
  end

endmodule

// File: doc/sd_stream_ctrl.md
Name: sd_stream_ctrl

Overview:
- Controller that feeds a bit-serial sequence detector from a parallel word interface.
- Accepts W-bit words through a valid/ready handshake and shifts each one MSB-first into an embedded overlapping pattern detector, one bit per clock.
- Counts detections per word and returns the count through a second valid/ready handshake.
- Sits between a word-oriented producer/consumer and the serial detector datapath.

Parameters:
- W, 8, data word width (>=2)
- PLEN, 3, pattern length in bits (2..W)
- PATTERN, 3'b100, pattern to detect, PLEN bits wide; the MSB is the oldest bit
- CW, $clog2(W+1), width of the count output (derived; do not override)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer has a word
- in_ready  out  1  controller can accept a word
- in_data  in  W  word to scan
- hist_clr  in  1  clear detector history (honoured only in IDLE)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_count  out  CW  detections in the last word
- out_hit  out  1  out_count != 0
- det_pulse  out  1  Mealy detect strobe for the bit currently shifted
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, shift reg=0, bit index=0, count=0, history=0, fill=0.
  - Outputs: in_ready=1, out_valid=0, out_count=0, out_hit=0, det_pulse=0, busy=0.
  - Reset mid-SHIFT or mid-REPORT aborts the word; no result is produced.
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data, count=0, bit index=W-1, go to SHIFT.
  - If hist_clr=1 in the same cycle as acceptance, or alone while IDLE: history=0 and fill=0 take effect before the first bit of the new word.
- SHIFT:
  - in_ready=0. One bit per cycle, MSB first (in_data[W-1] at the first SHIFT cycle).
  - Current bit b = shift reg MSB. Match when fill>=PLEN-1 and {history[PLEN-2:0], b}==PATTERN.
  - det_pulse=match (combinational in that cycle). count increments on match.
  - history shifts in b, fill saturates at PLEN-1, shift reg shifts left.
  - After bit index 0, go to REPORT.
  - hist_clr is ignored.
- REPORT:
  - out_valid=1; out_count/out_hit stay stable until the handshake.
  - On out_ready, go to IDLE. out_valid stays high until accepted, however long backpressure lasts.
  - in_ready=0; the next word is accepted no earlier than the cycle after the out handshake.
- Overlap and history:
  - Overlapping matches count.
  - History persists across words, so a pattern that spans a word boundary is credited to the later word.
- Latency: input accept at edge 0; SHIFT occupies cycles 1..W; out_valid is high from cycle W+1. Minimum throughput is one word per W+2 cycles.
- Arithmetic: count fits in CW bits (at most W matches); no overflow is possible.
- det_pulse=0 outside SHIFT.

Decomposition:
- Package sd_pkg:
  - state enum {IDLE, SHIFT, REPORT}
  - default PLEN/PATTERN constants
  - CW computation function
- Sub-module sd_match_core:
  - Inputs: bit_in, bit_en, clr.
  - Outputs: match.
  - Holds history and fill; parameterised by PLEN and PATTERN.
  - Combinational Mealy match, registered history.
- The controller owns the FSM, shift register, bit index, count and handshakes.

Test Plan:
- After reset, W=8, PATTERN=100: send 8'b1001_0010 with out_ready=1.
  - det_pulse fires on bits 2 and 5.
  - out_count=2, out_hit=1.
  - out_valid asserts exactly 9 cycles after acceptance.
- Boundary case: follow with 8'b0111_1111 without hist_clr.
  - The history "10" plus the first bit 0 gives a match.
  - out_count=1.
- Repeat the previous pair with hist_clr=1 asserted alongside the second word.
  - out_count=0.
  - Separately, 8'hFF gives out_count=0, out_hit=0.
- Backpressure: hold out_ready=0 for 5 cycles in REPORT.
  - out_valid, out_count and out_hit stay stable.
  - in_ready=0, and in_valid=1 is not accepted.
  - On release, IDLE follows after 1 cycle.
- Reset mid-SHIFT: drop rst_n at the 4th SHIFT cycle.
  - All outputs return to reset values immediately.
  - The next word 8'b1000_0000 gives out_count=1: no stale history, and fill gates the early bits.
- Back-to-back words with in_valid held high.
  - Each is accepted the cycle after the out handshake.
  - Counts match a reference model over 200 random words.
